// File: rtl/register_file_16_bit_if.sv
// Bus bundle for the 8 x 16-bit register file: one write port, two read ports.
// Signal names follow the datapath's established naming.
interface register_file_16_bit_if;
  logic        Write_En;
  logic [2:0]  Write_Addr;
  logic [15:0] Write_Data;
  logic [2:0]  Read_Addr_A;
  logic [2:0]  Read_Addr_B;
  logic [15:0] OutA;
  logic [15:0] OutB;

  // Datapath side: drives the write port and read addresses, receives the operands.
  modport master (
    output Write_En, Write_Addr, Write_Data, Read_Addr_A, Read_Addr_B,
    input  OutA, OutB
  );

  // Register file side.
  modport slave (
    input  Write_En, Write_Addr, Write_Data, Read_Addr_A, Read_Addr_B,
    output OutA, OutB
  );
endinterface

// File: rtl/register_file_16_bit.sv
// Eight-entry, 16-bit register file: one synchronous write port, two
// combinational read ports, asynchronous active-low clear of every entry.
// R0 is an ordinary register. There is no write-to-read bypass: a read of the
// entry being written shows the old value until the committing edge.
module register_file_16_bit (
  input  logic                          clk,
  input  logic                          clr,
  register_file_16_bit_if.slave         rf
);

  logic [7:0][15:0] regs_q;
  logic [7:0][15:0] regs_d;

  // Next-state: hold every entry, replace only the addressed one when enabled.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' and assign a full default
    // first, so no path leaves regs_d unassigned and no latch is inferred.
    regs_d = regs_q;
    if (rf.Write_En) begin
      regs_d[rf.Write_Addr] = rf.Write_Data;
    end
  end

  // State register: clear dominates any write; otherwise commit next-state.
  always_ff @(posedge clk or negedge clr) begin
    // NOTE: this storage is built from flops, so it can take the asynchronous
    // clear directly; a RAM macro could not, and would need a sweep instead.
    if (!clr) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read ports are plain muxes on the stored values.
  assign rf.OutA = regs_q[rf.Read_Addr_A];
  assign rf.OutB = regs_q[rf.Read_Addr_B];

endmodule

// File: tb/tb_register_file_16_bit.sv
// Self-checking bench for register_file_16_bit: directed scenarios plus a
// randomized run, all compared against a simple array model of the registers.
module tb_register_file_16_bit;

  logic clk = 1'b0;
  logic clr = 1'b0;

  register_file_16_bit_if rf ();

  register_file_16_bit dut (
    .clk (clk),
    .clr (clr),
    .rf  (rf.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference: the eight registers as a plain array.
  logic [15:0] model [8];

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) model[i] = 16'h0000;
  endtask

  // Sweep both ports over all addresses (B in reverse order) and compare.
  task automatic sweep(input string tag);
    for (int i = 0; i < 8; i++) begin
      rf.Read_Addr_A = 3'(i);
      rf.Read_Addr_B = 3'(7 - i);
      #1;
      check($sformatf("%s_A%0d", tag, i), rf.OutA, model[i]);
      check($sformatf("%s_B%0d", tag, 7 - i), rf.OutB, model[7 - i]);
    end
  endtask

  // One clock edge with an optional write; the model follows the write rule.
  task automatic write_cycle(input logic we, input logic [2:0] addr, input logic [15:0] data);
    @(negedge clk);
    rf.Write_En   = we;
    rf.Write_Addr = addr;
    rf.Write_Data = data;
    @(posedge clk);
    if (we && clr) model[addr] = data;
    #1;
  endtask

  logic [15:0] fill_vals [8];

  initial begin
    fill_vals = '{16'h0012, 16'h0034, 16'h0056, 16'h0078,
                  16'h009A, 16'h00BC, 16'h00DE, 16'h00F0};
    rf.Write_En    = 1'b0;
    rf.Write_Addr  = 3'd0;
    rf.Write_Data  = 16'h0000;
    rf.Read_Addr_A = 3'd0;
    rf.Read_Addr_B = 3'd0;
    model_clear();

    // Reset held with the clock running.
    #100;
    sweep("reset");

    // Release between edges, then fill R0..R7 one per cycle.
    @(negedge clk);
    clr = 1'b1;
    for (int i = 0; i < 8; i++) write_cycle(1'b1, 3'(i), fill_vals[i]);
    rf.Write_En = 1'b0;
    sweep("fill");
    rf.Read_Addr_A = 3'd0;
    #1;
    check("r0_writable", rf.OutA, 16'h0012);

    // Write disabled: R3 must survive several edges with junk on the bus.
    for (int i = 0; i < 4; i++) write_cycle(1'b0, 3'd3, 16'hFFFF);
    rf.Read_Addr_A = 3'd3;
    #1;
    check("wr_disable_r3", rf.OutA, 16'h0078);

    // Dual read of one register, then read-during-write without bypass.
    @(negedge clk);
    rf.Read_Addr_A = 3'd5;
    rf.Read_Addr_B = 3'd5;
    rf.Write_En    = 1'b1;
    rf.Write_Addr  = 3'd5;
    rf.Write_Data  = 16'hAAAA;
    #1;
    check("dual_pre_A", rf.OutA, 16'h00BC);
    check("dual_pre_B", rf.OutB, 16'h00BC);
    @(posedge clk);
    model[5] = 16'hAAAA;
    #1;
    check("dual_post_A", rf.OutA, 16'hAAAA);
    check("dual_post_B", rf.OutB, 16'hAAAA);
    rf.Write_En = 1'b0;

    // Back-to-back writes to the same address: last one wins.
    write_cycle(1'b1, 3'd6, 16'h1111);
    write_cycle(1'b1, 3'd6, 16'h2222);
    rf.Write_En = 1'b0;
    rf.Read_Addr_A = 3'd6;
    #1;
    check("b2b_last_wins", rf.OutA, 16'h2222);

    // Randomized traffic: reads checked before each edge (old value) and after.
    for (int n = 0; n < 300; n++) begin
      logic        we;
      logic [2:0]  wa;
      logic [15:0] wd;
      we = 1'($urandom_range(0, 1));
      wa = 3'($urandom_range(0, 7));
      wd = 16'($urandom);
      @(negedge clk);
      rf.Write_En    = we;
      rf.Write_Addr  = wa;
      rf.Write_Data  = wd;
      rf.Read_Addr_A = 3'($urandom_range(0, 7));
      rf.Read_Addr_B = (n % 4 == 0) ? wa : 3'($urandom_range(0, 7));
      #1;
      check("rand_pre_A", rf.OutA, model[rf.Read_Addr_A]);
      check("rand_pre_B", rf.OutB, model[rf.Read_Addr_B]);
      @(posedge clk);
      if (we) model[wa] = wd;
      #1;
      check("rand_post_A", rf.OutA, model[rf.Read_Addr_A]);
      check("rand_post_B", rf.OutB, model[rf.Read_Addr_B]);
    end
    rf.Write_En = 1'b0;

    // Asynchronous reset between edges: outputs drop before the next edge.
    write_cycle(1'b1, 3'd1, 16'h5A5A);
    write_cycle(1'b1, 3'd4, 16'hC3C3);
    rf.Write_En    = 1'b0;
    rf.Read_Addr_A = 3'd1;
    rf.Read_Addr_B = 3'd4;
    #1;
    check("pre_async_A", rf.OutA, 16'h5A5A);
    check("pre_async_B", rf.OutB, 16'hC3C3);
    @(negedge clk);
    #2;
    clr = 1'b0;
    #1;
    check("async_clr_A", rf.OutA, 16'h0000);
    check("async_clr_B", rf.OutB, 16'h0000);
    model_clear();
    @(negedge clk);
    clr = 1'b1;
    rf.Write_En = 1'b0;
    sweep("after_clr");

    // Reset dominates an enabled write; the next edge after release loads it.
    write_cycle(1'b1, 3'd2, 16'h9999);
    rf.Write_En = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    model_clear();
    write_cycle(1'b1, 3'd2, 16'h1234);
    rf.Read_Addr_A = 3'd2;
    #1;
    check("rst_vs_wr_r2", rf.OutA, 16'h0000);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    model[2] = 16'h1234;
    #1;
    check("first_wr_after_rst", rf.OutA, 16'h1234);
    rf.Write_En = 1'b0;
    sweep("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
